gate_reduce_acc: RTL and testbench

Parametrised, registered multi-input logic gate with selectable function and frame accumulation. It is the next generation of the fixed 5-input AND primitive. Each accepted input word is reduced to one bit by the selected gate function, with a registered per-word result. Results are also accumulated across a frame of DEPTH words into a single frame result. It sits between the lab stimulus/switch logic and the result display/monitor logic.

---
 rtl/gate_reduce_acc.sv | 152 +++++++++++++++
 tb/tb_gate_reduce_acc.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/gate_reduce_acc.sv
// Registered multi-input gate (AND/OR/XOR and inverted forms) that reduces each
// accepted word to one bit and accumulates the result across a DEPTH-word frame.
module gate_reduce_acc #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       mode,
  input  logic             clear,
  output logic             word_valid,
  output logic             word_out,
  output logic             frame_valid,
  output logic             frame_out,
  output logic [CW-1:0]    word_idx,
  output logic             mode_err
);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;
  typedef enum logic [1:0] {OP_AND = 2'd0, OP_OR = 2'd1, OP_XOR = 2'd2} op_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  function automatic logic reduce_word(input logic [WIDTH-1:0] d, input op_t op);
    case (op)
      OP_OR:   reduce_word = |d;
      OP_XOR:  reduce_word = ^d;
      default: reduce_word = &d;
    endcase
  endfunction

  function automatic logic combine(input logic a, input logic b, input op_t op);
    case (op)
      OP_OR:   combine = a | b;
      OP_XOR:  combine = a ^ b;
      default: combine = a & b;
    endcase
  endfunction

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            acc, acc_n;
  op_t             op_q, op_n;
  logic            inv_q, inv_n;
  logic            word_valid_n, word_out_n, frame_valid_n, frame_out_n, mode_err_n;
  logic [CW-1:0]   word_idx_n;

  // Decoded view of the live mode input; reserved codes fall back to plain AND.
  op_t             dec_op;
  logic            dec_inv, dec_err;
  logic            start;
  op_t             cur_op;
  logic            cur_inv, red, acc_base;
  logic [CW-1:0]   cur_idx;

  always_comb begin
    dec_op  = OP_AND;
    dec_inv = 1'b0;
    dec_err = 1'b0;
    case (mode)
      3'd0: dec_op = OP_AND;
      3'd1: dec_op = OP_OR;
      3'd2: dec_op = OP_XOR;
      3'd3: begin dec_op = OP_AND; dec_inv = 1'b1; end
      3'd4: begin dec_op = OP_OR;  dec_inv = 1'b1; end
      3'd5: begin dec_op = OP_XOR; dec_inv = 1'b1; end
      default: dec_err = 1'b1;
    endcase
  end

  // A word starts a new frame from IDLE, or when clear arrives alongside it.
  always_comb begin
    start    = in_valid && (state == IDLE || clear);
    cur_op   = start ? dec_op  : op_q;
    cur_inv  = start ? dec_inv : inv_q;
    cur_idx  = start ? '0 : cnt;
    red      = reduce_word(in_data, cur_op);
    acc_base = start ? red : combine(acc, red, cur_op);
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    acc_n         = acc;
    op_n          = op_q;
    inv_n         = inv_q;
    word_valid_n  = 1'b0;
    word_out_n    = word_out;
    word_idx_n    = word_idx;
    frame_valid_n = 1'b0;
    frame_out_n   = frame_out;
    mode_err_n    = mode_err;

    if (in_valid) begin
      if (start) begin
        op_n       = dec_op;
        inv_n      = dec_inv;
        mode_err_n = mode_err | dec_err;
      end
      word_valid_n = 1'b1;
      word_out_n   = cur_inv ^ red;
      word_idx_n   = cur_idx;
      if (cur_idx == LAST_IDX) begin
        frame_valid_n = 1'b1;
        frame_out_n   = cur_inv ^ acc_base;
        state_n       = IDLE;
        cnt_n         = '0;
        acc_n         = 1'b0;
      end else begin
        state_n = ACC;
        cnt_n   = cur_idx + 1'b1;
        acc_n   = acc_base;
      end
    end else if (clear) begin
      state_n = IDLE;
      cnt_n   = '0;
      acc_n   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= 1'b0;
      op_q        <= OP_AND;
      inv_q       <= 1'b0;
      word_valid  <= 1'b0;
      word_out    <= 1'b0;
      word_idx    <= '0;
      frame_valid <= 1'b0;
      frame_out   <= 1'b0;
      mode_err    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      acc         <= acc_n;
      op_q        <= op_n;
      inv_q       <= inv_n;
      word_valid  <= word_valid_n;
      word_out    <= word_out_n;
      word_idx    <= word_idx_n;
      frame_valid <= frame_valid_n;
      frame_out   <= frame_out_n;
      mode_err    <= mode_err_n;
    end
  end

endmodule

// File: tb/tb_gate_reduce_acc.sv
// Directed bench for gate_reduce_acc (WIDTH=5, DEPTH=4) with hand-computed
// word and frame results.
module tb_gate_reduce_acc;

  localparam int WIDTH = 5;
  localparam int DEPTH = 4;
  localparam int CW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       mode;
  logic             clear;
  logic             word_valid, word_out, frame_valid, frame_out, mode_err;
  logic [CW-1:0]    word_idx;

  int tests_run = 0;
  int tests_failed = 0;

  gate_reduce_acc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .mode        (mode),
    .clear       (clear),
    .word_valid  (word_valid),
    .word_out    (word_out),
    .frame_valid (frame_valid),
    .frame_out   (frame_out),
    .word_idx    (word_idx),
    .mode_err    (mode_err)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one word for one cycle and check the registered result.
  task automatic send(input string tag, input logic [WIDTH-1:0] d, input logic [2:0] m,
                      input logic clr, input logic exp_w, input int exp_idx,
                      input logic exp_fv, input logic exp_f);
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    clear    = clr;
    step();
    check({tag, ".wv"},  8'(word_valid),  8'd1);
    check({tag, ".w"},   8'(word_out),    8'(exp_w));
    check({tag, ".idx"}, 8'(word_idx),    8'(exp_idx));
    check({tag, ".fv"},  8'(frame_valid), 8'(exp_fv));
    if (exp_fv) check({tag, ".f"}, 8'(frame_out), 8'(exp_f));
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic idle(input string tag, input logic clr);
    in_valid = 1'b0;
    clear    = clr;
    step();
    check({tag, ".wv"}, 8'(word_valid),  8'd0);
    check({tag, ".fv"}, 8'(frame_valid), 8'd0);
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = 3'd0; clear = 1'b0;
    step(); step();
    check("rst.wv", 8'(word_valid), 8'd0);
    check("rst.w",  8'(word_out), 8'd0);
    check("rst.fv", 8'(frame_valid), 8'd0);
    check("rst.f",  8'(frame_out), 8'd0);
    check("rst.idx", 8'(word_idx), 8'd0);
    check("rst.err", 8'(mode_err), 8'd0);
    rst_n = 1'b1;
    idle("post_rst", 1'b0);

    // AND
    send("and0", 5'b00000, 3'd0, 0, 0, 0, 0, 0);
    send("and1", 5'b00101, 3'd0, 0, 0, 1, 0, 0);
    send("and2", 5'b11111, 3'd0, 0, 1, 2, 0, 0);
    send("and3", 5'b11111, 3'd0, 0, 1, 3, 1, 0);

    // NAND, then NAND with one 11110, back-to-back
    in_valid = 1'b1;
    send("nand0", 5'b11111, 3'd3, 0, 0, 0, 0, 0);
    send("nand1", 5'b11111, 3'd3, 0, 0, 1, 0, 0);
    send("nand2", 5'b11111, 3'd3, 0, 0, 2, 0, 0);
    send("nand3", 5'b11111, 3'd3, 0, 0, 3, 1, 0);
    send("nandb0", 5'b11111, 3'd3, 0, 0, 0, 0, 0);
    send("nandb1", 5'b11110, 3'd3, 0, 1, 1, 0, 0);
    send("nandb2", 5'b11111, 3'd3, 0, 0, 2, 0, 0);
    send("nandb3", 5'b11111, 3'd3, 0, 0, 3, 1, 1);

    // XOR parity 6 then 7
    send("xor0", 5'b00001, 3'd2, 0, 1, 0, 0, 0);
    send("xor1", 5'b00011, 3'd2, 0, 0, 1, 0, 0);
    send("xor2", 5'b00111, 3'd2, 0, 1, 2, 0, 0);
    send("xor3", 5'b00000, 3'd2, 0, 0, 3, 1, 0);
    idle("gap0", 1'b0);
    send("xorb0", 5'b00001, 3'd2, 0, 1, 0, 0, 0);
    idle("gap1", 1'b0);
    send("xorb1", 5'b00011, 3'd2, 0, 0, 1, 0, 0);
    send("xorb2", 5'b00111, 3'd2, 0, 1, 2, 0, 0);
    send("xorb3", 5'b10000, 3'd2, 0, 1, 3, 1, 1);

    // OR frame with mode switched to AND after word 0; next frame uses AND
    send("or0", 5'b00000, 3'd1, 0, 0, 0, 0, 0);
    send("or1", 5'b00001, 3'd0, 0, 1, 1, 0, 0);
    send("or2", 5'b00000, 3'd0, 0, 0, 2, 0, 0);
    send("or3", 5'b00000, 3'd0, 0, 0, 3, 1, 1);
    send("nx0", 5'b11111, 3'd0, 0, 1, 0, 0, 0);
    send("nx1", 5'b11111, 3'd1, 0, 1, 1, 0, 0);
    send("nx2", 5'b11111, 3'd1, 0, 1, 2, 0, 0);
    send("nx3", 5'b01111, 3'd1, 0, 0, 3, 1, 0);

    // clear on its own after 2 words
    send("ca0", 5'b00000, 3'd0, 0, 0, 0, 0, 0);
    send("ca1", 5'b11111, 3'd0, 0, 1, 1, 0, 0);
    idle("clr", 1'b1);
    send("cb0", 5'b11111, 3'd0, 0, 1, 0, 0, 0);
    send("cb1", 5'b11111, 3'd0, 0, 1, 1, 0, 0);
    send("cb2", 5'b11111, 3'd0, 0, 1, 2, 0, 0);
    send("cb3", 5'b11111, 3'd0, 0, 1, 3, 1, 1);

    // clear together with in_valid; new frame uses the current mode
    send("cc0", 5'b00000, 3'd1, 0, 0, 0, 0, 0);
    send("cc1", 5'b11111, 3'd1, 0, 1, 1, 0, 0);
    send("cd0", 5'b11111, 3'd0, 1, 1, 0, 0, 0);
    send("cd1", 5'b11111, 3'd0, 0, 1, 1, 0, 0);
    send("cd2", 5'b11111, 3'd0, 0, 1, 2, 0, 0);
    send("cd3", 5'b11111, 3'd0, 0, 1, 3, 1, 1);
    check("err.pre", 8'(mode_err), 8'd0);

    // reserved mode: AND, sticky mode_err
    send("m70", 5'b11111, 3'd7, 0, 1, 0, 0, 0);
    check("err.set", 8'(mode_err), 8'd1);
    send("m71", 5'b11111, 3'd7, 0, 1, 1, 0, 0);
    send("m72", 5'b11111, 3'd7, 0, 1, 2, 0, 0);
    send("m73", 5'b11111, 3'd7, 0, 1, 3, 1, 1);
    send("st0", 5'b11111, 3'd0, 0, 1, 0, 0, 0);
    check("err.sticky", 8'(mode_err), 8'd1);

    // reset mid-frame (frame started by st0)
    send("st1", 5'b00000, 3'd0, 0, 0, 1, 0, 0);
    rst_n = 1'b0;
    in_valid = 1'b1; in_data = 5'b11111;
    step();
    in_valid = 1'b0;
    check("mrst.wv", 8'(word_valid), 8'd0);
    check("mrst.w",  8'(word_out), 8'd0);
    check("mrst.fv", 8'(frame_valid), 8'd0);
    check("mrst.f",  8'(frame_out), 8'd0);
    check("mrst.idx", 8'(word_idx), 8'd0);
    check("mrst.err", 8'(mode_err), 8'd0);
    rst_n = 1'b1;
    send("pr0", 5'b11111, 3'd0, 0, 1, 0, 0, 0);
    send("pr1", 5'b11111, 3'd0, 0, 1, 1, 0, 0);
    send("pr2", 5'b11111, 3'd0, 0, 1, 2, 0, 0);
    send("pr3", 5'b11111, 3'd0, 0, 1, 3, 1, 1);
    idle("end", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
